// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and registered read data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency handshake, error flagging, traffic counters.
// Optional build macro DMEM_MISALIGN_CHECK_EN flags accesses with addr_i[1:0] != 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              ack_o,
  output logic              stall_o,
  output logic              err_o,
  output logic [WORD_W-1:0] rd_cnt_o,
  output logic [WORD_W-1:0] wr_cnt_o
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               opWrite_q, opErr_q, opBad_q;
  logic [IDX_W-1:0]   opIdx_q;
  logic [WORD_W-1:0]  opData_q;
  logic               ack_q, err_q, loadZero_q;
  logic [WORD_W-1:0]  rdCnt_q, wrCnt_q;

  logic               req, rangeErr, misErr, reqBad, reqErr;
  logic [IDX_W-1:0]   reqIdx;
  logic               curWrite, curErr, curBad, commit;
  logic [IDX_W-1:0]   curIdx;
  logic [WORD_W-1:0]  curData, ramData;

  assign req      = MemRead_i | MemWrite_i;
  assign rangeErr = (addr_i >> (IDX_W + BYTE_OFF_W)) != '0;
  assign reqIdx   = addr_i[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misErr = addr_i[BYTE_OFF_W-1:0] != '0;
`else
  logic unusedAddrLow;
  assign misErr        = 1'b0;
  assign unusedAddrLow = ^addr_i[BYTE_OFF_W-1:0];
`endif

  // "Bad" accesses touch no storage; a read/write conflict is still an error but commits as a store.
  assign reqBad = rangeErr | misErr;
  assign reqErr = reqBad | (MemRead_i & MemWrite_i);

  // With LATENCY = 1 the commit edge is the acceptance edge, so live inputs are used in IDLE.
  assign curWrite = (state_q == IDLE) ? MemWrite_i : opWrite_q;
  assign curErr   = (state_q == IDLE) ? reqErr     : opErr_q;
  assign curBad   = (state_q == IDLE) ? reqBad     : opBad_q;
  assign curIdx   = (state_q == IDLE) ? reqIdx     : opIdx_q;
  assign curData  = (state_q == IDLE) ? data_i     : opData_q;

  assign commit = !rst_i &
                  (((state_q == IDLE) & req & (LATENCY == 1)) |
                   ((state_q == WAIT) & (cnt_q == CNT_W'(1))));

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (commit & curWrite & !curBad),
    .re_i    (commit & !curWrite & !curBad),
    .idx_i   (curIdx),
    .wdata_i (curData),
    .rdata_o (ramData)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opWrite_q   <= 1'b0;
      opErr_q     <= 1'b0;
      opBad_q     <= 1'b0;
      opIdx_q     <= '0;
      opData_q    <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      loadZero_q  <= 1'b1;
      rdCnt_q     <= '0;
      wrCnt_q     <= '0;
    end else begin
      ack_q <= commit;
      err_q <= commit & curErr;
      if (commit & !curWrite) begin
        loadZero_q <= curBad;
      end
      if (commit & !curErr) begin
        if (curWrite) wrCnt_q <= wrCnt_q + 1'b1;
        else          rdCnt_q <= rdCnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req) begin
            opWrite_q <= MemWrite_i;
            opErr_q   <= reqErr;
            opBad_q   <= reqBad;
            opIdx_q   <= reqIdx;
            opData_q  <= data_i;
            cnt_q     <= CNT_W'(LATENCY - 1);
            state_q   <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
          else                    cnt_q   <= cnt_q - 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Error loads read as zero without disturbing the RAM's read register.
  assign data_o   = loadZero_q ? '0 : ramData;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign rd_cnt_o = rdCnt_q;
  assign wr_cnt_o = wrCnt_q;
  assign stall_o  = !rst_i & (((state_q == IDLE) & req) | (state_q == WAIT));

endmodule
